// File: rtl/edge_input.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : edge_input
// Purpose  : Rising-edge detector for a raw level input such as a button.
//            It has an optional synchronizer chain and an optional debounce
//            filter. It emits a single-cycle pulse each time the accepted
//            level goes from 0 to 1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES     : number of synchronizer flops ahead of the detector
//                     (0 = the raw input is used directly)
//   DEBOUNCE_CYCLES : number of consecutive cycles a new level must hold
//                     before it is accepted (0 = no debounce)
// Ports
//   clk   : in  1  single clock; all state updates on its rising edge
//   reset : in  1  synchronous, active-high reset
//   in    : in  1  raw level input
//   out   : out 1  one-cycle pulse on each accepted rising edge
//------------------------------------------------------------------------------
module edge_input #(
   parameter int SYNC_STAGES     = 0,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   logic s;       // sampled level seen by the detector
   logic acc;     // last accepted level
   logic pulse;   // edge pulse before reset gating

   //---------------------------------------------------------------------------
   // Optional synchronizer chain
   //---------------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_no_sync
         assign s = in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Edge detection, with or without debounce
   //---------------------------------------------------------------------------
   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
         // acc is simply s delayed by one cycle. The pulse is combinational,
         // so it is high in the same cycle in which s first reads 1.
         always_ff @(posedge clk) begin
            if (reset) begin
               acc <= 1'b0;
            end else begin
               acc <= s;
            end
         end

         assign pulse = s & ~acc;
      end else begin : g_debounce
         localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);
         localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

         logic [CNT_W-1:0] cnt;     // consecutive cycles s has differed from acc
         logic             out_q;   // registered edge pulse

         always_ff @(posedge clk) begin
            if (reset) begin
               acc   <= 1'b0;
               cnt   <= '0;
               out_q <= 1'b0;
            end else begin
               out_q <= 1'b0;
               if (s != acc) begin
                  if (cnt == LAST_COUNT) begin
                     // The new level has now held for DEBOUNCE_CYCLES samples.
                     // When the accepted level changes from 0 to 1, the
                     // registered pulse is high in the following cycle.
                     acc   <= s;
                     cnt   <= '0;
                     out_q <= s;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else begin
                  cnt <= '0;
               end
            end
         end

         assign pulse = out_q;
      end
   endgenerate

   // Reset also blocks the combinational path, so out stays low while reset
   // is held even if s is already high.
   assign out = pulse & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_edge_input.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_edge_input
// Purpose  : Self-checking bench for edge_input. Four configurations run side
//            by side on shared stimulus:
//              cfg0: S=0 N=0   cfg1: S=0 N=3   cfg2: S=2 N=0   cfg3: S=1 N=2
//            Each cycle, every output is compared with a reference model
//            built from the input and reset history.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_edge_input;

   localparam int NCFG = 4;
   localparam int S_OF [NCFG] = '{0, 0, 2, 1};
   localparam int N_OF [NCFG] = '{0, 3, 0, 2};

   logic clk = 1'b0;
   logic reset;
   logic in;
   logic out_a, out_b, out_c, out_d;

   always #5 clk = ~clk;

   edge_input #(.SYNC_STAGES(0), .DEBOUNCE_CYCLES(0)) u_a (.clk(clk), .reset(reset), .in(in), .out(out_a));
   edge_input #(.SYNC_STAGES(0), .DEBOUNCE_CYCLES(3)) u_b (.clk(clk), .reset(reset), .in(in), .out(out_b));
   edge_input #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u_c (.clk(clk), .reset(reset), .in(in), .out(out_c));
   edge_input #(.SYNC_STAGES(1), .DEBOUNCE_CYCLES(2)) u_d (.clk(clk), .reset(reset), .in(in), .out(out_d));

   int checks   = 0;
   int failures = 0;

   // History of completed cycles (one entry per clock edge)
   bit in_h  [$];
   bit rst_h [$];

   // Reference model state per configuration
   bit m_acc     [NCFG];
   bit m_run_val [NCFG];
   int m_run_len [NCFG];
   bit m_pend    [NCFG];

   logic obs    [NCFG];
   int   pulses [NCFG];

   task automatic check(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic check_int(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Level the detector sees in the current cycle: the input from S cycles
   // ago, or 0 if any reset occurred inside that window.
   function automatic bit sampled(input int stages, input bit cur_in);
      int idx;
      if (stages == 0) return cur_in;
      idx = in_h.size() - stages;
      if (idx < 0) return 1'b0;
      for (int j = idx; j < in_h.size(); j++)
         if (rst_h[j]) return 1'b0;
      return in_h[idx];
   endfunction

   // One clock cycle: apply inputs, check all outputs mid-cycle, then advance
   // the model across the rising edge.
   task automatic cycle(input bit v, input bit r);
      bit s [NCFG];
      bit e;
      in    = v;
      reset = r;
      @(negedge clk);
      obs[0] = out_a; obs[1] = out_b; obs[2] = out_c; obs[3] = out_d;
      for (int k = 0; k < NCFG; k++) begin
         s[k] = sampled(S_OF[k], v);
         if (N_OF[k] == 0) e = !r && s[k] && !m_acc[k];
         else              e = !r && m_pend[k];
         check($sformatf("cfg%0d_out_cyc%0d", k, in_h.size()), obs[k], e);
         if (obs[k] === 1'b1) pulses[k]++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NCFG; k++) begin
         if (r) begin
            m_acc[k] = 1'b0; m_run_len[k] = 0; m_pend[k] = 1'b0;
         end else if (N_OF[k] == 0) begin
            m_acc[k] = s[k];
         end else begin
            // Track how long the current level has held. It is accepted once it
            // has held N consecutive cycles and differs from the accepted level.
            if (m_run_len[k] == 0 || s[k] != m_run_val[k]) begin
               m_run_val[k] = s[k]; m_run_len[k] = 1;
            end else if (m_run_len[k] < 1000) begin
               m_run_len[k]++;
            end
            m_pend[k] = 1'b0;
            if (s[k] != m_acc[k] && m_run_len[k] >= N_OF[k]) begin
               m_acc[k]  = s[k];
               m_pend[k] = s[k];
            end
         end
      end
      in_h.push_back(v);
      rst_h.push_back(r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
   endtask

   task automatic clear_pulses();
      for (int k = 0; k < NCFG; k++) pulses[k] = 0;
   endtask

   initial begin
      int len;
      bit v, r;
      in    = 1'b1;
      reset = 1'b1;
      for (int k = 0; k < NCFG; k++) begin
         m_acc[k] = 0; m_run_val[k] = 0; m_run_len[k] = 0; m_pend[k] = 0; pulses[k] = 0;
      end

      // Reset held 3 cycles with in=1, then released with in still 1
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1);
         check("r027_reset_low", obs[0], 1'b0);
      end
      cycle(1'b1, 1'b0);
      check("r027_first_pulse", obs[0], 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0);
         check("r027_held_low", obs[0], 1'b0);
      end
      idle(6);

      // Ten isolated one-cycle highs
      clear_pulses();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0);
         check("r028_coincident", obs[0], 1'b1);
         idle(2);
      end
      idle(4);
      check_int("r028_count_a", pulses[0], 10);
      check_int("r028_count_b", pulses[1], 0);
      check_int("r028_count_c", pulses[2], 10);

      // High 5, low 1, high 3
      clear_pulses();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
      idle(6);
      check_int("r029_count_a", pulses[0], 2);
      check_int("r029_count_b", pulses[1], 1);

      // Back-to-back toggling
      clear_pulses();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0);
         cycle(1'b0, 1'b0);
      end
      idle(4);
      check_int("r022_toggle_a", pulses[0], 8);

      // Debounce: short high rejected, then exactly N highs accepted
      clear_pulses();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      idle(4);
      check_int("r030_short_b", pulses[1], 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0);
         check("r030_wait_b", obs[1], 1'b0);
      end
      cycle(1'b0, 1'b0);
      check("r030_pulse_b", obs[1], 1'b1);
      idle(6);
      check_int("r030_count_b", pulses[1], 1);

      // Two-stage synchronizer latency
      cycle(1'b1, 1'b0); check("r031_c_t0", obs[2], 1'b0);
      cycle(1'b1, 1'b0); check("r031_c_t1", obs[2], 1'b0);
      cycle(1'b1, 1'b0); check("r031_c_t2", obs[2], 1'b1);
      cycle(1'b1, 1'b0); check("r031_c_t3", obs[2], 1'b0);
      idle(6);

      // Reset in the cycle the input rises
      cycle(1'b1, 1'b1); check("r032_in_reset", obs[0], 1'b0);
      cycle(1'b1, 1'b0); check("r032_after",    obs[0], 1'b1);
      cycle(1'b1, 1'b0); check("r032_held",     obs[0], 1'b0);
      idle(6);

      // Reset in the middle of a debounce count
      clear_pulses();
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      idle(6);
      check_int("r026_abort_b", pulses[1], 0);

      // Randomized runs with occasional reset
      for (int i = 0; i < 80; i++) begin
         len = $urandom_range(1, 6);
         v   = 1'($urandom_range(0, 1));
         r   = ($urandom_range(0, 19) == 0);
         for (int j = 0; j < len; j++) cycle(v, r && (j == 0));
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
